// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, FU status-row layout and row state encoding for the issue stage.
package datapath_pkg;
   localparam int FUST_NUM_FU  = 5;
   localparam int FUST_NUM_SRC = 3;
   localparam int FUST_OP_W    = 8;
   localparam int REG_W        = 5;
   localparam int FUST_TAG_W   = $clog2(FUST_NUM_FU + 1);
   localparam int FUST_FU_W    = $clog2(FUST_NUM_FU);

   typedef enum logic [1:0] {FU_IDLE, FU_WAIT, FU_READY, FU_EXEC} fust_state_e;

   // tag 0 = operand ready, tag k = waiting on FU k-1
   typedef struct packed {
      logic                                        busy;
      logic                                        spec;
      logic [FUST_OP_W-1:0]                        op;
      logic [REG_W-1:0]                            rd;
      logic [FUST_NUM_SRC-1:0][REG_W-1:0]          rs;
      logic [FUST_NUM_SRC-1:0][FUST_TAG_W-1:0]     tag;
   } fust_row_t;
endpackage

// File: rtl/issue_fust_sched_if.sv
// issue_fust_sched_if: dispatch, writeback, branch and issue signals of the FU status-table scheduler.
interface issue_fust_sched_if;
   import datapath_pkg::*;
   logic                               disp_valid;
   logic [FUST_FU_W-1:0]               disp_fu;
   logic [FUST_OP_W-1:0]               disp_op;
   logic [REG_W-1:0]                   disp_rd;
   logic [FUST_NUM_SRC*REG_W-1:0]      disp_rs;
   logic [FUST_NUM_SRC*FUST_TAG_W-1:0] disp_tag;
   logic                               disp_spec;
   logic                               disp_halt;
   logic [FUST_NUM_FU-1:0]             disp_ready;
   logic [FUST_NUM_FU-1:0]             wb_valid;
   logic                               branch_miss;
   logic                               branch_resolved;
   logic                               freeze;
   logic                               issue_valid;
   logic [FUST_FU_W-1:0]               issue_fu;
   logic [FUST_OP_W-1:0]               issue_op;
   logic [REG_W-1:0]                   issue_rd;
   logic [FUST_NUM_SRC*REG_W-1:0]      issue_rs;
   logic [2*FUST_NUM_FU-1:0]           fust_state;
   logic                               halt;

   modport master (
      output disp_valid, disp_fu, disp_op, disp_rd, disp_rs, disp_tag, disp_spec, disp_halt,
             wb_valid, branch_miss, branch_resolved, freeze,
      input  disp_ready, issue_valid, issue_fu, issue_op, issue_rd, issue_rs, fust_state, halt
   );
   modport slave (
      input  disp_valid, disp_fu, disp_op, disp_rd, disp_rs, disp_tag, disp_spec, disp_halt,
             wb_valid, branch_miss, branch_resolved, freeze,
      output disp_ready, issue_valid, issue_fu, issue_op, issue_rd, issue_rs, fust_state, halt
   );
endinterface

// File: rtl/issue_rr_arbiter.sv
// issue_rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping modulo N.
module issue_rr_arbiter #(
   parameter int N = 5,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);
   logic [W-1:0] k;

   // scanning offsets downward leaves the closest one to ptr as the final winner
   always_comb begin
      gnt_valid = |req;
      gnt_idx = '0;
      k = '0;
      for (int i = N - 1; i >= 0; i--) begin
         k = W'((int'(ptr) + i) % N);
         if (req[k]) gnt_idx = k;
      end
   end
endmodule

// File: rtl/issue_fust_sched.sv
// issue_fust_sched: per-FU status table with tag wakeup, speculative squash, halt tracking
// and one round-robin issue per cycle.
module issue_fust_sched
   import datapath_pkg::*;
(
   input  logic CLK,
   input  logic nRST,
   issue_fust_sched_if.slave bus
);
   localparam int N  = FUST_NUM_FU;
   localparam int S  = FUST_NUM_SRC;
   localparam int TW = FUST_TAG_W;
   localparam int FW = FUST_FU_W;

   fust_state_e   st [N];
   fust_state_e   st_n [N];
   fust_row_t     row [N];
   fust_row_t     row_n [N];
   logic [FW-1:0] ptr, gnt_idx;
   logic [N-1:0]  req;
   logic [N:0]    wbx;
   logic          gnt_valid, accept, halt_acc, all_idle, pend, pend_spec, halt_q;

   // wbx[k] is the writeback of FU k-1, so tag 0 never matches
   function automatic logic [TW-1:0] wake(input logic [TW-1:0] t, input logic [N:0] w);
      return (int'(t) <= N && w[t]) ? '0 : t;
   endfunction

   assign wbx = {bus.wb_valid, 1'b0};
   assign accept = bus.disp_valid && !bus.disp_halt && int'(bus.disp_fu) < N && bus.disp_ready[bus.disp_fu];
   assign halt_acc = bus.disp_valid && bus.disp_halt && !bus.freeze && !bus.branch_miss;

   always_comb begin
      req = '0;
      bus.disp_ready = '0;
      bus.fust_state = '0;
      all_idle = 1'b1;
      for (int f = 0; f < N; f++) begin
         req[f] = st[f] == FU_READY;
         bus.disp_ready[f] = !bus.freeze && !bus.branch_miss &&
                             (st[f] == FU_IDLE || (st[f] == FU_EXEC && bus.wb_valid[f]));
         bus.fust_state[2*f +: 2] = st[f];
         all_idle &= !row[f].busy;
      end
   end

   issue_rr_arbiter #(.N(N)) u_arb (
      .req       (req),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign bus.issue_valid = gnt_valid && !bus.freeze;
   assign bus.issue_fu = bus.issue_valid ? gnt_idx : '0;
   assign bus.issue_op = bus.issue_valid ? row[gnt_idx].op : '0;
   assign bus.issue_rd = bus.issue_valid ? row[gnt_idx].rd : '0;
   assign bus.issue_rs = bus.issue_valid ? row[gnt_idx].rs : '0;
   assign bus.halt = halt_q;

   // later updates override earlier ones: wake, issue, complete, dispatch, squash
   always_comb begin
      for (int f = 0; f < N; f++) begin
         row_n[f] = row[f];
         st_n[f] = st[f];
         for (int s = 0; s < S; s++) row_n[f].tag[s] = wake(row[f].tag[s], wbx);
         if (st[f] == FU_WAIT && row_n[f].tag == '0) st_n[f] = FU_READY;
         if (bus.issue_valid && gnt_idx == FW'(f)) st_n[f] = FU_EXEC;
         if (st[f] == FU_EXEC && bus.wb_valid[f]) begin
            st_n[f] = FU_IDLE;
            row_n[f].busy = 1'b0;
         end
         if (bus.branch_resolved && !bus.branch_miss) row_n[f].spec = 1'b0;
         if (accept && bus.disp_fu == FW'(f)) begin
            row_n[f].busy = 1'b1;
            row_n[f].spec = bus.disp_spec;
            row_n[f].op = bus.disp_op;
            row_n[f].rd = bus.disp_rd;
            row_n[f].rs = bus.disp_rs;
            for (int s = 0; s < S; s++) row_n[f].tag[s] = wake(bus.disp_tag[s*TW +: TW], wbx);
            st_n[f] = row_n[f].tag == '0 ? FU_READY : FU_WAIT;
         end
         if (bus.branch_miss && row[f].spec && st[f] != FU_IDLE) begin
            st_n[f] = FU_IDLE;
            row_n[f].busy = 1'b0;
            row_n[f].spec = 1'b0;
            row_n[f].tag = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         st <= '{default: FU_IDLE};
         row <= '{default: '0};
         ptr <= '0;
         pend <= 1'b0;
         pend_spec <= 1'b0;
         halt_q <= 1'b0;
      end else begin
         st <= st_n;
         row <= row_n;
         if (bus.issue_valid) ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
         if (halt_acc) begin
            pend <= 1'b1;
            pend_spec <= bus.disp_spec;
         end else if (bus.branch_miss && pend_spec) begin
            pend <= 1'b0;
            pend_spec <= 1'b0;
         end else if (bus.branch_resolved) begin
            pend_spec <= 1'b0;
         end
         if (pend && all_idle) halt_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_issue_fust_sched.sv
// tb_issue_fust_sched: directed scenarios with an issue-order scoreboard and immediate-assertion checks.
module tb_issue_fust_sched;
   import datapath_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   int          compared = 0;
   int          mismatched = 0;
   logic [30:0] exp_q[$];

   issue_fust_sched_if bus();

   issue_fust_sched dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [30:0] pay(input int fu, input logic [7:0] op);
      logic [4:0] r;
      r = op[4:0];
      return {3'(fu), op, r, r ^ 5'd3, r ^ 5'd2, r ^ 5'd1};
   endfunction

   function automatic logic [1:0] st(input int f);
      return bus.fust_state[2*f +: 2];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      bus.disp_valid = 1'b0;
      bus.disp_fu = '0;
      bus.disp_op = '0;
      bus.disp_rd = '0;
      bus.disp_rs = '0;
      bus.disp_tag = '0;
      bus.disp_spec = 1'b0;
      bus.disp_halt = 1'b0;
      bus.wb_valid = '0;
      bus.branch_miss = 1'b0;
      bus.branch_resolved = 1'b0;
      bus.freeze = 1'b0;
   endtask

   task automatic disp(input int fu, input logic [7:0] op, input logic [2:0] t0, input logic spec);
      logic [30:0] p;
      p = pay(fu, op);
      bus.disp_valid = 1'b1;
      bus.disp_halt = 1'b0;
      bus.disp_fu = 3'(fu);
      bus.disp_op = op;
      bus.disp_rd = p[19:15];
      bus.disp_rs = p[14:0];
      bus.disp_tag = {3'd0, 3'd0, t0};
      bus.disp_spec = spec;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // scoreboard: every issue must match the oldest outstanding expectation
   always @(negedge CLK) begin
      if (bus.issue_valid) begin
         chk("issue_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0)
            chk("issue_payload", {1'b0, bus.issue_fu, bus.issue_op, bus.issue_rd, bus.issue_rs},
                {1'b0, exp_q.pop_front()});
      end
      if (nRST && bus.disp_valid && !bus.disp_halt)
         chk("disp_row_ready", 32'(bus.disp_ready[bus.disp_fu]), 1);
   end

   initial begin
      clr();
      tick();
      tick();
      #1;
      chk("rst_state", bus.fust_state, 0);
      chk("rst_issue", {bus.issue_valid, bus.issue_fu, bus.issue_op}, 0);
      chk("rst_halt", bus.halt, 0);
      chk("rst_disp_ready", bus.disp_ready, 5'h1f);
      nRST = 1'b1;

      // ready dispatch into row 2
      disp(2, 8'hA2, 0, 0);
      exp_q.push_back(pay(2, 8'hA2));
      tick(); clr(); #1;
      chk("rd_state_ready", st(2), FU_READY);
      chk("rd_issue_valid", bus.issue_valid, 1);
      chk("rd_issue_fu", bus.issue_fu, 2);
      tick(); #1;
      chk("rd_state_exec", st(2), FU_EXEC);
      chk("rd_exec_not_ready", bus.disp_ready[2], 0);
      bus.wb_valid = 5'b00100; #1;
      chk("rd_exec_wb_ready", bus.disp_ready[2], 1);
      tick(); clr(); #1;
      chk("rd_state_idle", st(2), FU_IDLE);
      chk("rd_idle_payload", {bus.issue_valid, bus.issue_op, bus.issue_rs}, 0);

      // dependence wakeup: row 0 waits on FU1
      disp(0, 8'h31, 3'd2, 0);
      tick(); clr(); #1;
      chk("wk_state_wait", st(0), FU_WAIT);
      chk("wk_no_issue", bus.issue_valid, 0);
      bus.wb_valid = 5'b00010;
      exp_q.push_back(pay(0, 8'h31));
      tick(); clr(); #1;
      chk("wk_state_ready", st(0), FU_READY);
      chk("wk_issue_fu", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd0});
      tick(); #1;
      chk("wk_state_exec", st(0), FU_EXEC);
      bus.wb_valid = 5'b00001;
      tick(); clr();
      // same-cycle bypass: tag 2 arrives with wb_valid[1]
      disp(3, 8'h47, 3'd2, 0);
      bus.wb_valid = 5'b00010;
      exp_q.push_back(pay(3, 8'h47));
      tick(); clr(); #1;
      chk("byp_state_ready", st(3), FU_READY);
      chk("byp_issue_fu", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd3});
      tick(); #1;
      bus.wb_valid = 5'b01000;
      tick(); clr();

      // round robin: bring pointer to 0 through row 4
      disp(4, 8'h54, 0, 0);
      exp_q.push_back(pay(4, 8'h54));
      tick(); clr();
      tick(); #1;
      bus.wb_valid = 5'b10000;
      tick(); clr();
      disp(0, 8'h60, 3'd3, 0);
      exp_q.push_back(pay(0, 8'h60));
      tick();
      disp(1, 8'h61, 3'd3, 0);
      exp_q.push_back(pay(1, 8'h61));
      tick();
      disp(3, 8'h63, 3'd3, 0);
      exp_q.push_back(pay(3, 8'h63));
      tick(); clr(); #1;
      chk("rr_all_wait", bus.fust_state, {2'd0, 2'(FU_WAIT), 2'd0, 2'(FU_WAIT), 2'(FU_WAIT)});
      bus.wb_valid = 5'b00100;
      tick(); clr(); #1;
      chk("rr_grant0", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd0});
      tick(); #1;
      chk("rr_grant1", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd1});
      bus.wb_valid = 5'b00001;
      disp(0, 8'h70, 0, 0);
      exp_q.push_back(pay(0, 8'h70));
      tick(); clr(); #1;
      chk("rr_grant3_before_refill", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd3});
      tick(); #1;
      chk("rr_wrap_grant0", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd0});
      tick(); #1;
      bus.wb_valid = 5'b01011;
      tick(); clr(); #1;
      chk("rr_all_idle", bus.fust_state, 0);

      // freeze with row 4 READY and row 0 waiting on FU1
      disp(0, 8'h80, 3'd2, 0);
      tick();
      disp(4, 8'h84, 0, 0);
      exp_q.push_back(pay(4, 8'h84));
      tick(); clr();
      bus.freeze = 1'b1; #1;
      chk("fz1_no_issue", bus.issue_valid, 0);
      chk("fz1_disp_blocked", bus.disp_ready, 0);
      chk("fz1_row4_ready", st(4), FU_READY);
      tick();
      bus.wb_valid = 5'b00010;
      exp_q.push_back(pay(0, 8'h80)); #1;
      chk("fz2_no_issue", bus.issue_valid, 0);
      chk("fz2_disp_blocked", bus.disp_ready, 0);
      tick();
      bus.wb_valid = '0; #1;
      chk("fz3_wake_under_freeze", st(0), FU_READY);
      chk("fz3_no_issue", bus.issue_valid, 0);
      chk("fz3_disp_blocked", bus.disp_ready, 0);
      tick();
      bus.freeze = 1'b0; #1;
      chk("fz_release_grant4", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd4});
      tick(); #1;
      chk("fz_then_grant0", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd0});
      tick(); #1;
      bus.wb_valid = 5'b10001;
      tick(); clr();

      // branch miss squashes only speculative rows
      disp(1, 8'h91, 0, 1);
      exp_q.push_back(pay(1, 8'h91));
      tick(); clr();
      tick();
      disp(3, 8'h93, 3'd3, 0);
      tick(); clr(); #1;
      chk("bm_before", {st(3), st(1)}, {2'(FU_WAIT), 2'(FU_EXEC)});
      bus.branch_miss = 1'b1; #1;
      chk("bm_disp_blocked", bus.disp_ready, 0);
      tick(); clr(); #1;
      chk("bm_row1_squashed", st(1), FU_IDLE);
      chk("bm_row3_kept", st(3), FU_WAIT);
      disp(1, 8'h95, 0, 1);
      exp_q.push_back(pay(1, 8'h95));
      tick(); clr();
      tick(); #1;
      bus.branch_resolved = 1'b1;
      tick(); clr(); #1;
      chk("br_resolved_kept", {st(3), st(1)}, {2'(FU_WAIT), 2'(FU_EXEC)});
      bus.branch_miss = 1'b1;
      tick(); clr(); #1;
      chk("br_late_miss_no_squash", {st(3), st(1)}, {2'(FU_WAIT), 2'(FU_EXEC)});
      bus.wb_valid = 5'b00110;
      exp_q.push_back(pay(3, 8'h93));
      tick(); clr(); #1;
      chk("br_row1_done", st(1), FU_IDLE);
      chk("br_row3_issue", {bus.issue_valid, bus.issue_fu}, {1'b1, 3'd3});
      tick(); #1;
      bus.wb_valid = 5'b01000;
      tick(); clr();

      // halt waits for the executing row to drain
      disp(2, 8'hA7, 0, 0);
      exp_q.push_back(pay(2, 8'hA7));
      tick(); clr();
      tick();
      bus.disp_valid = 1'b1;
      bus.disp_halt = 1'b1;
      tick(); clr(); #1;
      chk("ht_pending_busy", bus.halt, 0);
      chk("ht_row2_exec", st(2), FU_EXEC);
      tick(); #1;
      chk("ht_still_low", bus.halt, 0);
      bus.wb_valid = 5'b00100;
      tick(); clr(); #1;
      chk("ht_low_at_drain_edge", bus.halt, 0);
      tick(); #1;
      chk("ht_set", bus.halt, 1);
      tick(); #1;
      chk("ht_sticky", bus.halt, 1);

      // mid-run reset with busy rows
      disp(1, 8'hB1, 3'd3, 0);
      tick();
      disp(0, 8'hB0, 0, 0);
      exp_q.push_back(pay(0, 8'hB0));
      tick(); clr();
      tick(); #1;
      chk("mr_busy", {st(1), st(0)}, {2'(FU_WAIT), 2'(FU_EXEC)});
      nRST = 1'b0;
      tick(); #1;
      chk("mr_state", bus.fust_state, 0);
      chk("mr_halt", bus.halt, 0);
      chk("mr_issue", {bus.issue_valid, bus.issue_fu, bus.issue_op, bus.issue_rd, bus.issue_rs}, 0);
      nRST = 1'b1;
      tick(); #1;
      chk("mr_after_release", {bus.fust_state, bus.halt, bus.issue_valid}, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
